bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised N-digit BCD up/down counter with built-in tick prescaler and per-digit seven-segment decode, counting natively in BCD so no binary-to-BCD converter is needed. It replaces the fixed 16-bit counter, external clock divider and BCD converter chain in board-level display designs. It adds down-counting, wrap/saturate mode, synchronous load and an overflow flag. A top level instantiates it once and wires HEX slices straight to the display pins.

## Interface
- DIGITS, 5, number of BCD digits (1..8)
- DIV, 50000, prescaler ratio; one count step per DIV clocks (DIV >= 1)
- WRAP, 1, 1 = wrap at limits, 0 = saturate at limits

- CLOCK_50  in  1  system clock; all state updates on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- EN  in  1  count enable, level-sensitive, sampled on TICK cycles
- DOWN  in  1  0 = count up, 1 = count down
- CLR  in  1  synchronous clear of count and prescaler
- LOAD  in  1  synchronous load of LOAD_VAL
- LOAD_VAL  in  4*DIGITS  BCD load value; digit i in bits [4i+3:4i]
- BCD  out  4*DIGITS  current count; digit 0 = least significant
- HEX  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit; digit i in [7i+6:7i]
- TICK  out  1  prescaler pulse
- OVF  out  1  one-cycle limit-reached flag

## Operation
- Prescaler: free-running counter 0..DIV-1 of width clog2(DIV) (min 1), wraps to 0. TICK = (prescaler == DIV-1), combinational. DIV = 1 → TICK constantly high.
- Step condition: TICK & EN & ~CLR & ~LOAD.
- Priority per edge: CLR > LOAD > step > hold.
- CLR: BCD ← 0, prescaler ← 0, OVF ← 0.
- LOAD: BCD ← LOAD_VAL with any digit > 9 clamped to 9; prescaler unaffected; OVF ← 0.
- Up step: digit 0 increments; digit 9 → 0 with carry into next digit; ripple through all digits in one cycle.
- Down step: digit 0 decrements; digit 0 → 9 with borrow into next digit.
- Limits: up at all-9s, or down at all-0s.
  - WRAP=1: up → all 0s, down → all 9s.
  - WRAP=0: count holds.
  - Either mode: OVF ← 1.
- OVF is registered. It is 1 only in the cycle after a step edge that hit a limit, otherwise 0. It re-asserts on every step attempted at a saturated limit.
- HEX: combinational decode of BCD register. Active-low patterns: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000. BCD never holds > 9; default decode is blank (1111111).
- DOWN and EN changes take effect at the next TICK; no glitch or partial step.

## Timing
- Reset (RESET_N low, asynchronous, immediate):
  - prescaler = 0, BCD = 0, OVF = 0.
  - TICK = (DIV == 1).
  - HEX = 1000000 on every digit.
- After reset release, the first TICK is high in clock cycle DIV-1, counting the first edge as cycle 0. TICKs then recur every DIV cycles.
- Step latency: BCD and OVF update on the edge where the step condition is true; HEX follows combinationally in the same cycle.
- LOAD/CLR latency: one edge.
- Reset asserted mid-count clears everything asynchronously. The prescaler phase restarts from 0 on release.
- CLR held high: count stays 0 and TICK never fires while DIV > 1.

## Test plan
- Reset/prescale (DIGITS=3, DIV=4, WRAP=1, EN=1, DOWN=0): release reset → TICK high in cycles 3, 7, 11; BCD 000→001→002→003; HEX digit0 = 0100100 at count 2.
- Carry ripple: LOAD 099, then one step up → BCD = 100, OVF = 0. LOAD 199, DOWN=1, step → 198. LOAD 100, DOWN=1 → 099.
- Wrap: LOAD 999, step up → 000, OVF high exactly one cycle. LOAD 000, DOWN=1, step → 999 with OVF pulse.
- Saturate (WRAP=0): LOAD 999, three up steps → stays 999, OVF pulses on each TICK. DOWN=1 next TICK → 998, OVF = 0.
- Priority/clamp: CLR and LOAD asserted on the same TICK edge → BCD = 000, prescaler = 0. LOAD_VAL = {4'hC, 4'h5, 4'hA} → BCD = 959. EN=0 across TICKs → count unchanged.
- Async reset mid-operation: assert RESET_N low between edges at count 457 → BCD = 000, HEX all 1000000 immediately without a clock edge. Release → next TICK after DIV-1 cycles.

Source files
------------

// File: rtl/bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter_n
// Purpose  : N-digit BCD up/down counter with built-in tick prescaler and
//            per-digit active-low seven-segment decode. The count is held
//            natively in BCD, so no binary-to-BCD conversion is needed.
// Ports    : CLOCK_50  - system clock, rising edge
//            RESET_N   - asynchronous active-low reset
//            EN        - count enable, sampled on TICK cycles
//            DOWN      - 0 = count up, 1 = count down
//            CLR       - synchronous clear of count and prescaler
//            LOAD      - synchronous load of LOAD_VAL (digits clamped to 9)
//            LOAD_VAL  - BCD load value, digit i in [4i+3:4i]
//            BCD       - current count, digit 0 least significant
//            HEX       - active-low {g,f,e,d,c,b,a} per digit, digit i in [7i+6:7i]
//            TICK      - prescaler pulse (one count step per DIV clocks)
//            OVF       - one-cycle flag after a step that hit a limit
// Revision : 1.0 - initial release
// ============================================================================
module bcd_counter_n #(
    parameter int unsigned DIGITS = 5,
    parameter int unsigned DIV    = 50000,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  EN,
    input  logic                  DOWN,
    input  logic                  CLR,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  TICK,
    output logic                  OVF
);

    // Prescaler is at least one bit wide so DIV = 1 still elaborates;
    // in that case PRE_MAX = 0 and TICK is permanently high.
    localparam int unsigned     PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    // ------------------------------------------------------------------------
    // Seven-segment decode, active low {g,f,e,d,c,b,a}. Non-decimal codes
    // cannot occur in the count register but decode to blank for safety.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    // ------------------------------------------------------------------------
    // Per-digit arithmetic. Carry/borrow ripple through all digits in one
    // cycle: digit i changes only when every lower digit is at its rollover
    // value (9 going up, 0 going down). The final carry/borrow out is the
    // limit condition (all 9s / all 0s).
    // ------------------------------------------------------------------------
    logic [DIGITS:0]     w_carry;
    logic [DIGITS:0]     w_borrow;
    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic [4*DIGITS-1:0] w_load_clamped;

    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] w_d;
        logic [3:0] w_ld;
        logic       w_is9;
        logic       w_is0;

        assign w_d   = bcd_q[4*i +: 4];
        assign w_ld  = LOAD_VAL[4*i +: 4];
        assign w_is9 = (w_d == 4'd9);
        assign w_is0 = (w_d == 4'd0);

        assign w_carry[i+1]  = w_carry[i]  & w_is9;
        assign w_borrow[i+1] = w_borrow[i] & w_is0;

        assign w_inc[4*i +: 4] = !w_carry[i]  ? w_d :
                                 (w_is9 ? 4'd0 : w_d + 4'd1);
        assign w_dec[4*i +: 4] = !w_borrow[i] ? w_d :
                                 (w_is0 ? 4'd9 : w_d - 4'd1);

        // Out-of-range load digits saturate to 9 so the register never
        // holds a non-decimal code.
        assign w_load_clamped[4*i +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;

        assign HEX[7*i +: 7] = seg7(w_d);
    end : g_digit

    logic w_at_limit;
    logic [4*DIGITS-1:0] w_step_val;

    // Ripple from all 9s naturally yields all 0s (and all 0s yields all 9s
    // going down), so the wrap value needs no special case.
    assign w_at_limit = DOWN ? w_borrow[DIGITS] : w_carry[DIGITS];
    assign w_step_val = DOWN ? w_dec : w_inc;

    // ------------------------------------------------------------------------
    // Prescaler tick
    // ------------------------------------------------------------------------
    assign TICK = (pre_q == PRE_MAX);

    // ------------------------------------------------------------------------
    // Next-state: CLR > LOAD > step > hold
    // ------------------------------------------------------------------------
    always_comb begin
        pre_d = pre_q;
        bcd_d = bcd_q;
        ovf_d = 1'b0;

        if (CLR) begin
            pre_d = '0;
            bcd_d = '0;
        end else begin
            pre_d = TICK ? '0 : pre_q + PRE_W'(1);

            if (LOAD) begin
                bcd_d = w_load_clamped;
            end else if (TICK && EN) begin
                if (w_at_limit) begin
                    ovf_d = 1'b1;
                    if (WRAP) begin
                        bcd_d = w_step_val;
                    end
                end else begin
                    bcd_d = w_step_val;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q <= '0;
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
        end
    end

    assign BCD = bcd_q;
    assign OVF = ovf_q;

endmodule : bcd_counter_n
`default_nettype wire

// File: tb/tb_bcd_counter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_counter_n
// Purpose  : Directed testbench for bcd_counter_n. Two instances (wrap and
//            saturate) share stimulus; a behavioural decimal model predicts
//            each edge, expectations go through a scoreboard queue and are
//            compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_counter_n;

    localparam int D    = 3;
    localparam int DV   = 4;
    localparam int MAXV = 999;

    logic            clk;
    logic            rst_n;
    logic            en, down, clr, load;
    logic [4*D-1:0]  load_val;
    logic [4*D-1:0]  bcd_w, bcd_s;
    logic [7*D-1:0]  hex_w, hex_s;
    logic            tick_w, tick_s, ovf_w, ovf_s;

    bcd_counter_n #(.DIGITS(D), .DIV(DV), .WRAP(1'b1)) u_dut_wrap (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .EN       (en),
        .DOWN     (down),
        .CLR      (clr),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .BCD      (bcd_w),
        .HEX      (hex_w),
        .TICK     (tick_w),
        .OVF      (ovf_w)
    );

    bcd_counter_n #(.DIGITS(D), .DIV(DV), .WRAP(1'b0)) u_dut_sat (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .EN       (en),
        .DOWN     (down),
        .CLR      (clr),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .BCD      (bcd_s),
        .HEX      (hex_s),
        .TICK     (tick_s),
        .OVF      (ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Decimal reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [4*D-1:0] bcd_w;
        logic           ovf_w;
        logic [7*D-1:0] hex_w;
        logic           tick;
        logic [4*D-1:0] bcd_s;
        logic           ovf_s;
    } exp_t;

    exp_t sb[$];

    int   pre_m, val_w, val_s;
    logic ovf_wm, ovf_sm;
    bit   stepped;
    int   n_cmp, n_bad;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*D-1:0] hex_of(input int v);
        logic [7*D-1:0] r;
        int p;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[7*i +: 7] = seg((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [4*D-1:0] lv);
        int s, p, dg;
        s = 0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            dg = int'(lv[4*i +: 4]);
            if (dg > 9) dg = 9;
            s = s + dg * p;
            p = p * 10;
        end
        return s;
    endfunction

    task automatic adv(inout int v, inout logic o, input bit wrap);
        if (!down) begin
            if (v == MAXV) begin
                o = 1'b1;
                if (wrap) v = 0;
            end else begin
                v = v + 1;
                o = 1'b0;
            end
        end else begin
            if (v == 0) begin
                o = 1'b1;
                if (wrap) v = MAXV;
            end else begin
                v = v - 1;
                o = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        pre_m  = 0;
        val_w  = 0;
        val_s  = 0;
        ovf_wm = 1'b0;
        ovf_sm = 1'b0;
    endtask

    // Predict the state after the coming rising edge from current inputs.
    task automatic model_edge();
        bit tk;
        tk = (pre_m == DV - 1);
        stepped = 1'b0;
        if (!rst_n || clr) begin
            model_reset();
        end else begin
            pre_m = tk ? 0 : pre_m + 1;
            if (load) begin
                val_w  = clamp_val(load_val);
                val_s  = val_w;
                ovf_wm = 1'b0;
                ovf_sm = 1'b0;
            end else if (tk && en) begin
                stepped = 1'b1;
                adv(val_w, ovf_wm, 1'b1);
                adv(val_s, ovf_sm, 1'b0);
            end else begin
                ovf_wm = 1'b0;
                ovf_sm = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic step_cycle();
        exp_t e;
        model_edge();
        e.bcd_w = to_bcd(val_w);
        e.ovf_w = ovf_wm;
        e.hex_w = hex_of(val_w);
        e.tick  = (pre_m == DV - 1);
        e.bcd_s = to_bcd(val_s);
        e.ovf_s = ovf_sm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("bcd_wrap", 32'(bcd_w),  32'(e.bcd_w));
        check("ovf_wrap", 32'(ovf_w),  32'(e.ovf_w));
        check("hex_wrap", 32'(hex_w),  32'(e.hex_w));
        check("tick",     32'(tick_w), 32'(e.tick));
        check("bcd_sat",  32'(bcd_s),  32'(e.bcd_s));
        check("ovf_sat",  32'(ovf_s),  32'(e.ovf_s));
    endtask

    task automatic load_cycle(input logic [4*D-1:0] v);
        load     = 1'b1;
        load_val = v;
        step_cycle();
        load     = 1'b0;
    endtask

    // Clock until a count step has been taken, bounded.
    task automatic run_to_step();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2 * DV && !done; i++) begin
            step_cycle();
            done = stepped;
        end
        check("step_timeout", 32'(done), 32'd1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        down     = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        model_reset();

        // Reset state
        #1;
        check("rst_bcd",  32'(bcd_w),  32'd0);
        check("rst_hex",  32'(hex_w),  32'({D{7'b1000000}}));
        check("rst_tick", 32'(tick_w), 32'd0);
        check("rst_ovf",  32'(ovf_w),  32'd0);
        step_cycle();
        step_cycle();

        // Prescale and basic up count
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 3 * DV; i++) begin
            step_cycle();
            if (val_w == 2) check("hex_d0_two", 32'(hex_w[6:0]), 32'(7'b0100100));
        end
        check("count_003", 32'(bcd_w), 32'h003);

        // Carry and borrow ripple
        load_cycle(12'h099);
        run_to_step();
        check("ripple_up_100", 32'(bcd_w), 32'h100);
        check("ripple_up_ovf", 32'(ovf_w), 32'd0);
        down = 1'b1;
        load_cycle(12'h199);
        run_to_step();
        check("down_198", 32'(bcd_w), 32'h198);
        load_cycle(12'h100);
        run_to_step();
        check("borrow_099", 32'(bcd_w), 32'h099);

        // Wrap at limits
        down = 1'b0;
        load_cycle(12'h999);
        run_to_step();
        check("wrap_up_000", 32'(bcd_w), 32'h000);
        check("wrap_up_ovf", 32'(ovf_w), 32'd1);
        step_cycle();
        check("wrap_ovf_drop", 32'(ovf_w), 32'd0);
        down = 1'b1;
        load_cycle(12'h000);
        run_to_step();
        check("wrap_dn_999", 32'(bcd_w), 32'h999);
        check("wrap_dn_ovf", 32'(ovf_w), 32'd1);

        // Saturate at limits
        down = 1'b0;
        load_cycle(12'h999);
        for (int k = 0; k < 3; k++) begin
            run_to_step();
            check("sat_hold_999", 32'(bcd_s), 32'h999);
            check("sat_ovf", 32'(ovf_s), 32'd1);
        end
        down = 1'b1;
        run_to_step();
        check("sat_dn_998", 32'(bcd_s), 32'h998);
        check("sat_dn_ovf", 32'(ovf_s), 32'd0);

        // CLR beats LOAD on a tick edge; prescaler restarts
        for (int i = 0; i < DV && pre_m != DV - 1; i++) step_cycle();
        check("tick_before_clr", 32'(tick_w), 32'd1);
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 12'h555;
        step_cycle();
        clr  = 1'b0;
        load = 1'b0;
        check("clr_prio_bcd", 32'(bcd_w), 32'h000);
        n = 0;
        while (tick_w !== 1'b1 && n < 3 * DV) begin
            step_cycle();
            n++;
        end
        check("clr_pre_phase", 32'(n), 32'(DV - 1));

        // Digit clamp on load, then hold with EN low
        load_cycle(12'hC5A);
        check("clamp_959", 32'(bcd_w), 32'h959);
        en = 1'b0;
        for (int i = 0; i < 2 * DV; i++) step_cycle();
        check("en_low_hold", 32'(bcd_w), 32'h959);

        // Asynchronous reset between edges
        en   = 1'b1;
        down = 1'b0;
        load_cycle(12'h457);
        check("pre_rst_457", 32'(bcd_w), 32'h457);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_bcd", 32'(bcd_w), 32'd0);
        check("async_hex", 32'(hex_w), 32'({D{7'b1000000}}));
        check("async_ovf", 32'(ovf_w), 32'd0);
        model_reset();
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
        n = 0;
        while (tick_w !== 1'b1 && n < 3 * DV) begin
            step_cycle();
            n++;
        end
        check("post_rst_tick", 32'(n), 32'(DV - 1));
        run_to_step();
        check("post_rst_001", 32'(bcd_w), 32'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bcd_counter_n
`default_nettype wire
